// File: rtl/mc_fifo_mon_pkg.sv
// mc_fifo_mon_pkg: shared tracker state type and occupancy width helper for mc_fifo_monitor.
package mc_fifo_mon_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, DONE} t_trk_state;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_chan_monitor.sv
// fifo_chan_monitor: one-channel occupancy model, data-integrity tracker and sticky error flags.
// SVA checks and covers are emitted only when MC_FIFO_MON_ASSERT_EN is defined.
module fifo_chan_monitor
  import mc_fifo_mon_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int T_SIZE = 3,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p2f_irdy,
  input  logic [T_SIZE-1:0] data_in,
  input  logic              f2p_trdy,
  input  logic              f2c_irdy,
  input  logic [T_SIZE-1:0] data_out,
  input  logic              c2f_trdy,
  input  logic              start_tracking,
  output logic [OCC_W-1:0]  occupancy,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_data,
  output logic              trk_done
);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
  t_trk_state state, state_n;
  logic enq, deq, ovf, unf, trk_unf, mism;
  logic [OCC_W-1:0] occ_n, cnt, cnt_n;
  logic [T_SIZE-1:0] tdata, tdata_n;
  assign enq = p2f_irdy & f2p_trdy;
  assign deq = f2c_irdy & c2f_trdy;
  assign ovf = (occupancy == FULL) & enq;
  assign unf = (occupancy == '0) & deq;
  assign occ_n = ovf ? FULL : unf ? '0 : occupancy + OCC_W'(enq) - OCC_W'(deq);
  assign trk_done = (state == DONE);
  // counter holds the number of entries still ahead of the tracked one
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tdata_n = tdata;
    trk_unf = 1'b0;
    mism = 1'b0;
    case (state)
      IDLE: if (start_tracking && enq && !ovf) begin
        state_n = TRACK;
        tdata_n = data_in;
        cnt_n = (occupancy == '0) ? '0 : occupancy - OCC_W'(deq);
      end
      TRACK: if (deq) begin
        if (cnt != '0) cnt_n = cnt - OCC_W'(1);
        else begin
          mism = (data_out != tdata);
          state_n = DONE;
        end
      end else if (occupancy == '0 && !enq) begin
        trk_unf = 1'b1;
        state_n = DONE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      occupancy <= '0;
      cnt <= '0;
      tdata <= '0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
      err_data <= 1'b0;
    end else begin
      state <= state_n;
      occupancy <= occ_n;
      cnt <= cnt_n;
      tdata <= tdata_n;
      err_overflow <= err_overflow | ovf;
      err_underflow <= err_underflow | unf | trk_unf;
      err_data <= err_data | mism;
    end
  end
`ifdef MC_FIFO_MON_ASSERT_EN
  no_overflow: assert property (@(posedge clk) disable iff (rst) !ovf);
  no_underflow: assert property (@(posedge clk) disable iff (rst) !unf);
  data_integrity: assert property (@(posedge clk) disable iff (rst)
    (state == TRACK && deq && cnt == '0) |-> data_out == tdata);
  cnt_lt_occ: assert property (@(posedge clk) disable iff (rst) state == TRACK |-> cnt < occupancy);
  cov_track_deq: cover property (@(posedge clk) disable iff (rst) state == TRACK && deq);
  cov_track_cnt0: cover property (@(posedge clk) disable iff (rst) state == TRACK && cnt == '0);
  cov_done: cover property (@(posedge clk) disable iff (rst) state == DONE);
`endif
endmodule

// File: rtl/mc_fifo_monitor.sv
// mc_fifo_monitor: passive checker for CH independent FIFOs; one fifo_chan_monitor per channel.
// Optional SVA per channel via MC_FIFO_MON_ASSERT_EN.
module mc_fifo_monitor
  import mc_fifo_mon_pkg::*;
#(
  parameter int CH = 2,
  parameter int DEPTH = 8,
  parameter int T_SIZE = 3,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        p2f_irdy,
  input  logic [CH*T_SIZE-1:0] data_in,
  input  logic [CH-1:0]        f2p_trdy,
  input  logic [CH-1:0]        f2c_irdy,
  input  logic [CH*T_SIZE-1:0] data_out,
  input  logic [CH-1:0]        c2f_trdy,
  input  logic [CH-1:0]        start_tracking,
  output logic [CH*OCC_W-1:0]  occupancy,
  output logic [CH-1:0]        err_overflow,
  output logic [CH-1:0]        err_underflow,
  output logic [CH-1:0]        err_data,
  output logic [CH-1:0]        trk_done,
  output logic                 err_any
);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    fifo_chan_monitor #(.DEPTH(DEPTH), .T_SIZE(T_SIZE), .OCC_W(OCC_W)) u_mon (
      .clk(clk),
      .rst(rst),
      .p2f_irdy(p2f_irdy[c]),
      .data_in(data_in[c*T_SIZE +: T_SIZE]),
      .f2p_trdy(f2p_trdy[c]),
      .f2c_irdy(f2c_irdy[c]),
      .data_out(data_out[c*T_SIZE +: T_SIZE]),
      .c2f_trdy(c2f_trdy[c]),
      .start_tracking(start_tracking[c]),
      .occupancy(occupancy[c*OCC_W +: OCC_W]),
      .err_overflow(err_overflow[c]),
      .err_underflow(err_underflow[c]),
      .err_data(err_data[c]),
      .trk_done(trk_done[c])
    );
  end
  assign err_any = |{err_overflow, err_underflow, err_data};
endmodule

// File: tb/tb_mc_fifo_monitor.sv
// tb_mc_fifo_monitor: directed plus randomized check of mc_fifo_monitor (CH=2, DEPTH=4, T_SIZE=3)
// against a behavioural per-channel model.
module tb_mc_fifo_monitor;
  localparam int CH = 2, DEPTH = 4, TS = 3, OW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [CH-1:0] p2f_irdy, f2p_trdy, f2c_irdy, c2f_trdy, start_tracking;
  logic [CH*TS-1:0] data_in, data_out;
  logic [CH*OW-1:0] occupancy;
  logic [CH-1:0] err_overflow, err_underflow, err_data, trk_done;
  logic err_any;
  int errors = 0, checks = 0;
  int m_occ[CH], m_cnt[CH], m_st[CH];
  bit m_ov[CH], m_un[CH], m_dt[CH];
  int m_td[CH];

  mc_fifo_monitor #(.CH(CH), .DEPTH(DEPTH), .T_SIZE(TS)) dut (
    .clk(clk), .rst(rst), .p2f_irdy(p2f_irdy), .data_in(data_in), .f2p_trdy(f2p_trdy),
    .f2c_irdy(f2c_irdy), .data_out(data_out), .c2f_trdy(c2f_trdy),
    .start_tracking(start_tracking), .occupancy(occupancy), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_data(err_data), .trk_done(trk_done), .err_any(err_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // tracker states in the model: 0 idle, 1 tracking, 2 done
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_occ[c] = 0; m_cnt[c] = 0; m_st[c] = 0; m_td[c] = 0;
        m_ov[c] = 0; m_un[c] = 0; m_dt[c] = 0;
      end else begin
        bit e, d, ov, un;
        int nocc;
        e = p2f_irdy[c] & f2p_trdy[c];
        d = f2c_irdy[c] & c2f_trdy[c];
        ov = (m_occ[c] == DEPTH) && e;
        un = (m_occ[c] == 0) && d;
        nocc = ov ? DEPTH : un ? 0 : m_occ[c] + int'(e) - int'(d);
        if (m_st[c] == 0) begin
          if (start_tracking[c] && e && !ov) begin
            m_st[c] = 1;
            m_td[c] = int'(data_in[c*TS +: TS]);
            m_cnt[c] = (m_occ[c] - int'(d) < 0) ? 0 : m_occ[c] - int'(d);
          end
        end else if (m_st[c] == 1) begin
          if (d) begin
            if (m_cnt[c] > 0) m_cnt[c]--;
            else begin
              if (int'(data_out[c*TS +: TS]) != m_td[c]) m_dt[c] = 1;
              m_st[c] = 2;
            end
          end else if (m_occ[c] == 0 && !e) begin
            un = 1;
            m_st[c] = 2;
          end
        end
        m_ov[c] |= ov;
        m_un[c] |= un;
        m_occ[c] = nocc;
      end
    end
  endtask

  task automatic tick();
    bit any;
    model_step();
    @(posedge clk);
    #1;
    any = 0;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("occ%0d", c), int'(occupancy[c*OW +: OW]), m_occ[c]);
      check($sformatf("ovf%0d", c), int'(err_overflow[c]), int'(m_ov[c]));
      check($sformatf("unf%0d", c), int'(err_underflow[c]), int'(m_un[c]));
      check($sformatf("dat%0d", c), int'(err_data[c]), int'(m_dt[c]));
      check($sformatf("done%0d", c), int'(trk_done[c]), int'(m_st[c] == 2));
      any |= m_ov[c] | m_un[c] | m_dt[c];
    end
    check("err_any", int'(err_any), int'(any));
  endtask

  task automatic drv(input logic [1:0] p, ft, fi, ct, st, input logic [5:0] di, dout);
    p2f_irdy = p; f2p_trdy = ft; f2c_irdy = fi; c2f_trdy = ct; start_tracking = st;
    data_in = di; data_out = dout;
  endtask

  task automatic idle(); drv(0, 0, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic track_seq(input logic [2:0] last);
    do_reset();
    drv(2'b01, 2'b01, 0, 0, 0, 6'o02, 0); tick(); tick();
    drv(2'b01, 2'b01, 0, 0, 2'b01, 6'o05, 0); tick();
    check("lit_occ_trk", int'(occupancy[2:0]), 3);
    drv(0, 0, 2'b01, 2'b01, 0, 0, 6'o07); tick(); tick();
    check("lit_done_early", int'(trk_done[0]), 0);
    drv(0, 0, 2'b01, 2'b01, 0, 0, {3'b000, last}); tick();
    idle();
    check("lit_trk_done", int'(trk_done[0]), 1);
    check("lit_err_data", int'(err_data[0]), int'(last != 3'b101));
    check("lit_err_any_d", int'(err_any), int'(last != 3'b101));
  endtask

  initial begin
    idle();
    rst = 1; tick(); tick(); rst = 0;
    check("lit_rst_occ", int'(occupancy), 0);
    check("lit_rst_any", int'(err_any), 0);
    drv(2'b01, 2'b01, 0, 0, 0, 6'o03, 0);
    repeat (4) tick();
    check("lit_full0", int'(occupancy[2:0]), 4);
    check("lit_empty1", int'(occupancy[5:3]), 0);
    check("lit_noerr", int'(err_any), 0);
    drv(2'b01, 2'b01, 2'b01, 2'b01, 0, 0, 0); tick();
    idle();
    check("lit_ovf", int'(err_overflow), 1);
    check("lit_ovf_occ", int'(occupancy[2:0]), 4);
    drv(0, 0, 2'b10, 2'b10, 0, 0, 0); tick();
    idle();
    check("lit_unf", int'(err_underflow), 2);
    check("lit_unf_occ", int'(occupancy[5:3]), 0);
    do_reset();
    check("lit_clr", int'({err_overflow, err_underflow, err_data}), 0);
    track_seq(3'b101);
    track_seq(3'b110);
    do_reset();
    drv(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 6'o04, 0); tick();
    idle();
    check("lit_bypass_unf", int'(err_underflow[0]), 1);
    rst = 1; tick(); rst = 0;
    check("lit_rst_trk", int'(trk_done[0]), 0);
    tick();
    check("lit_no_residue", int'(err_underflow[0]), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      p2f_irdy = 2'($urandom); f2p_trdy = 2'($urandom);
      f2c_irdy = 2'($urandom); c2f_trdy = 2'($urandom);
      start_tracking = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      data_in = 6'($urandom); data_out = 6'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_fifo_monitor.md
Name: mc_fifo_monitor

Overview:
- Parametrised, multi-channel successor to the team's single-FIFO checker.
- Passively observes CH independent FIFOs, each with producer irdy/trdy and consumer irdy/trdy handshakes.
- Per channel: keeps an occupancy model, runs a one-shot data-integrity tracker, and reports sticky overflow, underflow and data-mismatch flags as registered outputs.
- Synthesisable, so it runs in emulation as well as in formal; it has no dependence on DUT internals.

Parameters:
- CH, 2, number of monitored channels (>=1).
- DEPTH, 8, capacity of each monitored FIFO (>=2, need not be a power of 2).
- T_SIZE, 3, data width per channel.
- OCC_W, $clog2(DEPTH+1), occupancy width; derived, must hold the value DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- p2f_irdy  in  CH  producer valid, per channel.
- data_in  in  CH*T_SIZE  producer data; channel c occupies bits [c*T_SIZE +: T_SIZE].
- f2p_trdy  in  CH  FIFO ready to producer.
- f2c_irdy  in  CH  FIFO valid to consumer.
- data_out  in  CH*T_SIZE  consumer-side data; same packing as data_in.
- c2f_trdy  in  CH  consumer ready.
- start_tracking  in  CH  arms the tracker on the next enqueue; free input for formal.
- occupancy  out  CH*OCC_W  modelled occupancy per channel.
- err_overflow  out  CH  sticky overflow flag.
- err_underflow  out  CH  sticky underflow flag.
- err_data  out  CH  sticky data-mismatch flag.
- trk_done  out  CH  tracker has checked its entry.
- err_any  out  1  OR of all error bits.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: occupancy=0, all err_* flags=0, trk_done=0, err_any=0, tracker=IDLE, counter=0, tracked data=0.
- Handshake events per channel:
  - enq = p2f_irdy & f2p_trdy.
  - deq = f2c_irdy & c2f_trdy.
  - Channels are fully independent.
- Occupancy update, next value:
  - normally occ + enq - deq;
  - on an overflow event, held at DEPTH;
  - on an underflow event, held at 0.
- Overflow event: occ==DEPTH & enq, regardless of deq. Full-FIFO passthrough is illegal.
- Underflow event: occ==0 & deq, regardless of enq. Empty-FIFO bypass is illegal.
- Error flags:
  - err_* are registered and assert the cycle after the offending event.
  - They are sticky until rst.
  - err_any is a combinational OR of the registered flags.
- Tracker FSM per channel, states IDLE, TRACK, DONE:
  - IDLE -> TRACK when start_tracking & enq & no overflow event. Capture data_in. Set counter = occ - deq, clamped at 0.
  - TRACK with deq & counter!=0: counter decrements.
  - TRACK with deq & counter==0: compare data_out against the tracked data; a mismatch sets err_data. Go to DONE.
  - TRACK with occ==0 & no enq: set err_underflow (model inconsistency) and go to DONE.
  - DONE is terminal until rst. trk_done = (state==DONE).
- Simultaneous events: a capture and a deq in the same cycle use pre-update occ. The tracked entry is never the one dequeued in its own enqueue cycle unless occ==0, which is an underflow event.
- Counter width is OCC_W. Counter is always < DEPTH.
- Reset mid-operation: all state returns to reset values on the next edge; no residue is retained.

Optional Feature:
- MC_FIFO_MON_ASSERT_EN defined:
  - Each channel additionally instantiates concurrent assertions: no_overflow, no_underflow, data_integrity, counter<occ while TRACK.
  - Adds cover properties: TRACK&deq, TRACK&counter==0, DONE reached.
  - All are disabled iff rst.
- Undefined: flag outputs only; no SVA is emitted, which keeps the block synthesis-clean for emulation.
- Flag behaviour is identical either way.

Decomposition:
- Package mc_fifo_mon_pkg:
  - t_trk_state enum {IDLE, TRACK, DONE};
  - function occ_width(depth) returning $clog2(depth+1).
- Sub-module fifo_chan_monitor: one channel, containing the occupancy model, tracker FSM, flags and optional SVA.
- Top: a generate loop of CH instances, plus port slicing and err_any.

Test Plan (CH=2, DEPTH=4, T_SIZE=3):
- Reset, then 4 enq on ch0 with no deq -> occupancy[0]=4, no errors; ch1 occupancy stays 0.
- ch0 full (occ=4), enq and deq together -> err_overflow[0]=1 next cycle, occupancy[0] stays 4, ch1 flags stay 0.
- ch1 empty, deq asserted -> err_underflow[1]=1 next cycle, occupancy[1]=0; issue rst -> all flags 0.
- ch0 holding 2 entries: start_tracking with enq data 3'b101; 2 deq; 3rd deq with data_out=3'b101 -> trk_done[0]=1, err_data[0]=0.
- Same sequence as above, but 3rd deq presents data_out=3'b110 -> err_data[0]=1, err_any=1, trk_done[0]=1.
- ch0 empty: start_tracking with enq and deq in the same cycle -> err_underflow[0]=1; assert rst while in TRACK -> tracker IDLE, trk_done[0]=0.
